// File: rtl/id_stage_pkg.sv
// Shared types for the decode stage: instruction layout, opcodes, ALU source selects.
package id_stage_pkg;

    localparam int DATA_W  = 8;
    localparam int ADR_W   = 3;
    localparam int INSTR_W = 22;

    localparam int OPC_HI  = 21;
    localparam int OPC_LO  = 18;
    localparam int DST_HI  = 17;
    localparam int DST_LO  = 15;
    localparam int SRC1_HI = 14;
    localparam int SRC1_LO = 12;
    localparam int SRC2_HI = 11;
    localparam int SRC2_LO = 9;
    localparam int ISEL_B  = 8;
    localparam int IMM_HI  = 7;
    localparam int IMM_LO  = 0;

    typedef logic [DATA_W-1:0] t_data;
    typedef logic [ADR_W-1:0]  t_RFadrs;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SHL  = 4'd5,
        OP_SHR  = 4'd6,
        OP_MOV  = 4'd7,
        OP_LDI  = 4'd8,
        OP_OUT  = 4'd9,
        OP_HALT = 4'd14,
        OP_NOP  = 4'd15
    } t_opcode;

    typedef enum logic [1:0] {
        SRC_REG  = 2'd0,
        SRC_IMM  = 2'd1,
        SRC_ZERO = 2'd2
    } t_ALUsrc_ctrl;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } t_state;

    typedef struct packed {
        logic [3:0] op;
        t_RFadrs    dst;
        t_RFadrs    src1;
        t_RFadrs    src2;
        logic       isel;
        t_data      imm;
    } t_instr;

    typedef struct packed {
        logic         issue;
        logic         halt;
        logic         wr_en;
        logic         outv;
        t_ALUsrc_ctrl src1;
        t_ALUsrc_ctrl src2;
        t_opcode      aluop;
        logic         use1;
        logic         use2;
    } t_ctrl;

    // Unlisted opcodes (10-13) fall through to a non-issuing bubble.
    function automatic t_ctrl decode(input t_instr ins);
        t_ctrl c;
        c       = '0;
        c.src1  = SRC_ZERO;
        c.src2  = SRC_ZERO;
        c.aluop = OP_NOP;
        unique case (ins.op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SHL, OP_SHR: begin
                c.issue = 1'b1;
                c.wr_en = 1'b1;
                c.src1  = SRC_REG;
                c.src2  = ins.isel ? SRC_IMM : SRC_REG;
                c.aluop = t_opcode'(ins.op);
                c.use1  = 1'b1;
                c.use2  = !ins.isel;
            end
            OP_MOV: begin
                c.issue = 1'b1;
                c.wr_en = 1'b1;
                c.src1  = SRC_REG;
                c.aluop = OP_OR;
                c.use1  = 1'b1;
            end
            OP_LDI: begin
                c.issue = 1'b1;
                c.wr_en = 1'b1;
                c.src2  = SRC_IMM;
                c.aluop = OP_OR;
            end
            OP_OUT: begin
                c.issue = 1'b1;
                c.outv  = 1'b1;
                c.src1  = SRC_REG;
                c.aluop = OP_OR;
                c.use1  = 1'b1;
            end
            OP_HALT: c.halt = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// ID -> EX control/data bundle.
interface reg_IDtoEX;
    import id_stage_pkg::*;

    logic         wr_enx0;
    t_ALUsrc_ctrl ALUsrc1x0;
    t_ALUsrc_ctrl ALUsrc2x0;
    t_opcode      ALUopx0;
    t_data        immx0;
    t_data        dat1x0;
    t_data        dat2x0;
    t_RFadrs      dstx0;
    logic         dataoutvx0;

    modport driver (
        output wr_enx0, ALUsrc1x0, ALUsrc2x0, ALUopx0,
        output immx0, dat1x0, dat2x0, dstx0, dataoutvx0
    );

    modport receiver (
        input wr_enx0, ALUsrc1x0, ALUsrc2x0, ALUopx0,
        input immx0, dat1x0, dat2x0, dstx0, dataoutvx0
    );

endinterface

// File: rtl/id_stage_reg_file.sv
// Two-read, one-write register file with write-through bypass.
module reg_file
    import id_stage_pkg::*;
#(
    parameter int NUM_REGS  = 8,
    parameter bit ZERO_REG0 = 1'b1
) (
    input  logic    clock,
    input  logic    reset_n,
    input  t_RFadrs rd1_adr,
    input  t_RFadrs rd2_adr,
    output t_data   rd1_data,
    output t_data   rd2_data,
    input  logic    we,
    input  t_RFadrs wr_adr,
    input  t_data   wr_data
);

    t_data r_mem [NUM_REGS];
    logic  w_wr_ok;

    assign w_wr_ok = we
                   && !(ZERO_REG0 && wr_adr == '0)
                   && (int'(wr_adr) < NUM_REGS);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[wr_adr] <= wr_data;
        end
    end

    always_comb begin
        rd1_data = '0;
        if (ZERO_REG0 && rd1_adr == '0) begin
            rd1_data = '0;
        end else if (w_wr_ok && rd1_adr == wr_adr) begin
            rd1_data = wr_data;
        end else if (int'(rd1_adr) < NUM_REGS) begin
            rd1_data = r_mem[rd1_adr];
        end
    end

    always_comb begin
        rd2_data = '0;
        if (ZERO_REG0 && rd2_adr == '0) begin
            rd2_data = '0;
        end else if (w_wr_ok && rd2_adr == wr_adr) begin
            rd2_data = wr_data;
        end else if (int'(rd2_adr) < NUM_REGS) begin
            rd2_data = r_mem[rd2_adr];
        end
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: instruction decode, RAW scoreboard against the instruction in EX, RUN/HALT control.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int NUM_REGS  = 8,
    parameter bit ZERO_REG0 = 1'b1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_v,
    output logic               id_ready,
    input  logic               flush,
    input  logic               resume,
    input  logic               wb_we,
    input  t_RFadrs            wb_dst,
    input  t_data              wb_data,
    reg_IDtoEX.driver          id2ex,
    output logic               halted
);

    t_state  r_state;
    logic    r_pend_v;
    t_RFadrs r_pend_dst;

    t_instr  w_ins;
    t_ctrl   w_dec;
    t_data   w_rd1;
    t_data   w_rd2;
    logic    w_pend_live;
    logic    w_hit1;
    logic    w_hit2;
    logic    w_hazard;
    logic    w_run;
    logic    w_accept;
    logic    w_issue;
    logic    w_go_halt;

    assign w_ins = t_instr'(instr);
    assign w_dec = decode(w_ins);

    reg_file #(
        .NUM_REGS  (NUM_REGS),
        .ZERO_REG0 (ZERO_REG0)
    ) u_rf (
        .clock    (clock),
        .reset_n  (reset_n),
        .rd1_adr  (w_ins.src1),
        .rd2_adr  (w_ins.src2),
        .rd1_data (w_rd1),
        .rd2_data (w_rd2),
        .we       (wb_we),
        .wr_adr   (wb_dst),
        .wr_data  (wb_data)
    );

    // A pending write to R0 never creates a dependency when R0 is hardwired.
    assign w_pend_live = r_pend_v && (r_pend_dst != '0 || !ZERO_REG0);
    assign w_hit1      = w_dec.use1 && (w_ins.src1 == r_pend_dst);
    assign w_hit2      = w_dec.use2 && (w_ins.src2 == r_pend_dst);
    assign w_hazard    = instr_v && w_pend_live && (w_hit1 || w_hit2);

    assign w_run     = reset_n && (r_state == ST_RUN);
    assign w_accept  = w_run && instr_v && !flush && !w_hazard;
    assign w_issue   = w_accept && w_dec.issue;
    assign w_go_halt = w_accept && w_dec.halt;

    assign id_ready = w_run && !(instr_v && !flush && w_hazard);
    assign halted   = (r_state == ST_HALT);

    always_comb begin
        id2ex.wr_enx0    = 1'b0;
        id2ex.dataoutvx0 = 1'b0;
        id2ex.ALUsrc1x0  = SRC_ZERO;
        id2ex.ALUsrc2x0  = SRC_ZERO;
        id2ex.ALUopx0    = OP_NOP;
        id2ex.immx0      = '0;
        id2ex.dat1x0     = '0;
        id2ex.dat2x0     = '0;
        id2ex.dstx0      = '0;
        if (w_issue) begin
            id2ex.wr_enx0    = w_dec.wr_en;
            id2ex.dataoutvx0 = w_dec.outv;
            id2ex.ALUsrc1x0  = w_dec.src1;
            id2ex.ALUsrc2x0  = w_dec.src2;
            id2ex.ALUopx0    = w_dec.aluop;
            id2ex.immx0      = w_ins.imm;
            id2ex.dat1x0     = w_rd1;
            id2ex.dat2x0     = w_rd2;
            id2ex.dstx0      = w_ins.dst;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_RUN;
            r_pend_v   <= 1'b0;
            r_pend_dst <= '0;
        end else begin
            r_pend_v   <= w_issue && w_dec.wr_en;
            r_pend_dst <= w_issue ? w_ins.dst : '0;
            unique case (r_state)
                ST_RUN:  if (w_go_halt) r_state <= ST_HALT;
                ST_HALT: if (resume)    r_state <= ST_RUN;
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed vectors push expected outputs, a monitor compares each cycle.
module tb_id_stage;

    localparam logic [1:0] R = 2'd0;
    localparam logic [1:0] I = 2'd1;
    localparam logic [1:0] Z = 2'd2;

    typedef struct packed {
        logic       rdy;
        logic       hlt;
        logic       we;
        logic       ov;
        logic [1:0] s1;
        logic [1:0] s2;
        logic [3:0] op;
        logic [7:0] imm;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [2:0] dst;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [21:0] instr;
    logic        instr_v;
    logic        id_ready;
    logic        flush;
    logic        resume;
    logic        wb_we;
    logic [2:0]  wb_dst;
    logic [7:0]  wb_data;
    logic        halted;

    exp_t  q [$];
    string nq [$];
    int    n_chk  = 0;
    int    n_pass = 0;

    always #5 clock = ~clock;

    reg_IDtoEX u_bus ();

    id_stage #(
        .NUM_REGS  (8),
        .ZERO_REG0 (1'b1)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .instr    (instr),
        .instr_v  (instr_v),
        .id_ready (id_ready),
        .flush    (flush),
        .resume   (resume),
        .wb_we    (wb_we),
        .wb_dst   (wb_dst),
        .wb_data  (wb_data),
        .id2ex    (u_bus),
        .halted   (halted)
    );

    function automatic logic [21:0] mk(input logic [3:0] op, input logic [2:0] d,
                                       input logic [2:0] s1, input logic [2:0] s2,
                                       input logic is, input logic [7:0] imm);
        return {op, d, s1, s2, is, imm};
    endfunction

    function automatic exp_t bub(input logic rdy, input logic hlt);
        exp_t e;
        e     = '0;
        e.rdy = rdy;
        e.hlt = hlt;
        e.s1  = Z;
        e.s2  = Z;
        e.op  = 4'd15;
        return e;
    endfunction

    function automatic exp_t iss(input logic we, input logic ov,
                                 input logic [1:0] s1, input logic [1:0] s2,
                                 input logic [3:0] op, input logic [7:0] imm,
                                 input logic [7:0] d1, input logic [7:0] d2,
                                 input logic [2:0] dst);
        exp_t e;
        e.rdy = 1'b1;
        e.hlt = 1'b0;
        e.we  = we;
        e.ov  = ov;
        e.s1  = s1;
        e.s2  = s2;
        e.op  = op;
        e.imm = imm;
        e.d1  = d1;
        e.d2  = d2;
        e.dst = dst;
        return e;
    endfunction

    task automatic cyc(input string nm, input logic [21:0] ins, input logic v,
                       input logic fl, input logic rs, input logic we,
                       input logic [2:0] wd, input logic [7:0] wv, input exp_t e);
        instr   = ins;
        instr_v = v;
        flush   = fl;
        resume  = rs;
        wb_we   = we;
        wb_dst  = wd;
        wb_data = wv;
        q.push_back(e);
        nq.push_back(nm);
        @(posedge clock);
        #1;
    endtask

    // Monitor: the DUT presents a (possibly bubble) bundle every cycle.
    initial begin : monitor
        exp_t  e;
        exp_t  a;
        string nm;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e     = q.pop_front();
                nm    = nq.pop_front();
                a.rdy = id_ready;
                a.hlt = halted;
                a.we  = u_bus.wr_enx0;
                a.ov  = u_bus.dataoutvx0;
                a.s1  = u_bus.ALUsrc1x0;
                a.s2  = u_bus.ALUsrc2x0;
                a.op  = u_bus.ALUopx0;
                a.imm = u_bus.immx0;
                a.d1  = u_bus.dat1x0;
                a.d2  = u_bus.dat2x0;
                a.dst = u_bus.dstx0;
                n_chk++;
                if (a === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got rdy=%b hlt=%b we=%b ov=%b s1=%0d s2=%0d op=%0d imm=%h d1=%h d2=%h dst=%0d, expected rdy=%b hlt=%b we=%b ov=%b s1=%0d s2=%0d op=%0d imm=%h d1=%h d2=%h dst=%0d",
                             nm, a.rdy, a.hlt, a.we, a.ov, a.s1, a.s2, a.op, a.imm, a.d1, a.d2, a.dst,
                             e.rdy, e.hlt, e.we, e.ov, e.s1, e.s2, e.op, e.imm, e.d1, e.d2, e.dst);
                end
            end
        end
    end

    initial begin : stim
        reset_n = 1'b0;
        instr   = '0;
        instr_v = 1'b0;
        flush   = 1'b0;
        resume  = 1'b0;
        wb_we   = 1'b0;
        wb_dst  = '0;
        wb_data = '0;
        @(posedge clock);
        #1;

        cyc("in_reset",    mk(0,1,3,3,0,8'h00), 1, 0, 0, 0, 0, 8'h00, bub(0,0));
        reset_n = 1'b1;
        cyc("wb_r3",       mk(0,0,0,0,0,8'h00), 0, 0, 0, 1, 3, 8'h5A, bub(1,0));
        cyc("add_r3_r3",   mk(0,1,3,3,0,8'h07), 1, 0, 0, 0, 0, 8'h00, iss(1,0,R,R,0,8'h07,8'h5A,8'h5A,1));
        cyc("sub_imm_ff",  mk(1,6,3,0,1,8'hFF), 1, 0, 0, 0, 0, 8'h00, iss(1,0,R,I,1,8'hFF,8'h5A,8'h00,6));
        cyc("ldi_r2",      mk(8,2,0,0,0,8'h11), 1, 0, 0, 0, 0, 8'h00, iss(1,0,Z,I,3,8'h11,8'h00,8'h00,2));
        cyc("raw_stall",   mk(0,4,2,0,0,8'h00), 1, 0, 0, 1, 2, 8'h11, bub(0,0));
        cyc("raw_issue",   mk(0,4,2,0,0,8'h00), 1, 0, 0, 0, 0, 8'h00, iss(1,0,R,R,0,8'h00,8'h11,8'h00,4));
        cyc("out_bypass",  mk(9,0,5,0,0,8'h00), 1, 0, 0, 1, 5, 8'h33, iss(0,1,R,Z,3,8'h00,8'h33,8'h00,0));
        cyc("mov_r7",      mk(7,7,5,0,0,8'h00), 1, 0, 0, 0, 0, 8'h00, iss(1,0,R,Z,3,8'h00,8'h33,8'h00,7));
        cyc("src2_stall",  mk(2,3,0,7,0,8'h00), 1, 0, 0, 0, 0, 8'h00, bub(0,0));
        cyc("src2_issue",  mk(2,3,0,7,0,8'h00), 1, 0, 0, 0, 0, 8'h00, iss(1,0,R,R,2,8'h00,8'h00,8'h00,3));
        cyc("isel_nohaz",  mk(5,1,0,3,1,8'h02), 1, 0, 0, 0, 0, 8'h00, iss(1,0,R,I,5,8'h02,8'h00,8'h5A,1));
        cyc("ldi_r0",      mk(8,0,0,0,0,8'h99), 1, 0, 0, 1, 0, 8'hFF, iss(1,0,Z,I,3,8'h99,8'h00,8'h00,0));
        cyc("r0_nohaz",    mk(0,1,0,0,0,8'h00), 1, 0, 0, 1, 0, 8'hEE, iss(1,0,R,R,0,8'h00,8'h00,8'h00,1));
        cyc("undef_op",    mk(11,3,1,1,0,8'h55),1, 0, 0, 0, 0, 8'h00, bub(1,0));
        cyc("ldi_r2_b",    mk(8,2,0,0,0,8'h22), 1, 0, 0, 0, 0, 8'h00, iss(1,0,Z,I,3,8'h22,8'h00,8'h00,2));
        cyc("flush_haz",   mk(0,4,2,0,0,8'h00), 1, 1, 0, 0, 0, 8'h00, bub(1,0));
        cyc("after_flush", mk(0,4,2,0,0,8'h00), 1, 0, 0, 0, 0, 8'h00, iss(1,0,R,R,0,8'h00,8'h11,8'h00,4));
        cyc("halt_dec",    mk(14,0,0,0,0,8'h00),1, 0, 0, 0, 0, 8'h00, bub(1,0));
        cyc("halt_c1",     mk(0,1,3,3,0,8'h00), 1, 0, 0, 0, 0, 8'h00, bub(0,1));
        cyc("halt_c2",     mk(0,1,3,3,0,8'h00), 1, 1, 0, 0, 0, 8'h00, bub(0,1));
        cyc("halt_c3_wb",  mk(0,1,3,3,0,8'h00), 1, 0, 0, 1, 6, 8'h66, bub(0,1));
        cyc("halt_resume", mk(0,1,3,3,0,8'h00), 1, 0, 1, 0, 0, 8'h00, bub(0,1));
        cyc("run_again",   mk(0,1,6,3,0,8'h00), 1, 0, 1, 0, 0, 8'h00, iss(1,0,R,R,0,8'h00,8'h66,8'h5A,1));
        cyc("ldi_r2_c",    mk(8,2,0,0,0,8'h44), 1, 0, 0, 0, 0, 8'h00, iss(1,0,Z,I,3,8'h44,8'h00,8'h00,2));
        cyc("stall_b4rst", mk(0,4,2,0,0,8'h00), 1, 0, 0, 0, 0, 8'h00, bub(0,0));
        reset_n = 1'b0;
        cyc("rst_in_stall",mk(0,4,2,0,0,8'h00), 1, 0, 0, 0, 0, 8'h00, bub(0,0));
        reset_n = 1'b1;
        cyc("post_rst",    mk(0,4,2,0,0,8'h00), 1, 0, 0, 0, 0, 8'h00, iss(1,0,R,R,0,8'h00,8'h00,8'h00,4));
        cyc("rf_cleared",  mk(9,0,3,0,0,8'h00), 1, 0, 0, 0, 0, 8'h00, iss(0,1,R,Z,3,8'h00,8'h00,8'h00,0));
        cyc("halt_dec_b",  mk(14,0,0,0,0,8'h00),1, 0, 0, 0, 0, 8'h00, bub(1,0));
        reset_n = 1'b0;
        cyc("rst_in_halt", mk(0,1,3,3,0,8'h00), 1, 0, 0, 0, 0, 8'h00, bub(0,0));
        reset_n = 1'b1;
        cyc("post_rst_h",  mk(0,1,0,0,1,8'h80), 1, 0, 0, 0, 0, 8'h00, iss(1,0,R,I,0,8'h80,8'h00,8'h00,1));

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(negedge clock);
        end
        #1;
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending entries, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
